// File: rtl/alu_pkg.sv
// Shared opcode constants and control-state encoding for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] OP_PASS = 4'd0;
   localparam logic [3:0] OP_NOT  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_ADD  = 4'd5;
   localparam logic [3:0] OP_SUB  = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;
   localparam logic [3:0] OP_EQZ  = 4'd10;
   localparam logic [3:0] OP_NEZ  = 4'd11;
   localparam logic [3:0] OP_GTZ  = 4'd12;
   localparam logic [3:0] OP_LTZ  = 4'd13;
   localparam logic [3:0] OP_MUL  = 4'd14;
   localparam logic [3:0] OP_DIVU = 4'd15;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ITER = 1'b1
   } state_t;

   function automatic logic is_iterative(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per clock.
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             last,
   output logic [WIDTH-1:0] result,
   output logic             flag
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t          state;
   logic [CW-1:0]   count;
   logic            div_mode;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;

   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   // One step of each algorithm; a non-negative trial difference sets the quotient bit.
   always_comb begin
      acc_next = acc + (mplier[0] ? mcand : '0);
      shifted  = {rem, quo[WIDTH-1]};
      diff     = shifted - {1'b0, dvs};
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
      if (!diff[WIDTH]) begin
         rem_next = diff[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end
   end

   assign last   = busy && (count == CNT_LAST);
   assign result = div_mode ? quo_next : acc_next;
   assign flag   = div_mode ? (dvs != '0) : 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         count    <= '0;
         div_mode <= 1'b0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (go) begin
                  state    <= ST_ITER;
                  busy     <= 1'b1;
                  count    <= '0;
                  div_mode <= is_div;
                  acc      <= '0;
                  mcand    <= a;
                  mplier   <= b;
                  rem      <= '0;
                  quo      <= a;
                  dvs      <= b;
               end
            end
            ST_ITER: begin
               acc    <= acc_next;
               mcand  <= {mcand[WIDTH-2:0], 1'b0};
               mplier <= {1'b0, mplier[WIDTH-1:1]};
               rem    <= rem_next;
               quo    <= quo_next;
               count  <= count + 1'b1;
               if (count == CNT_LAST) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops computed here, MUL/DIVU delegated to alu_muldiv.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       sel,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] C,
   output logic             cmp,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] SHAMT_LIMIT = WIDTH'(WIDTH);

   logic             accept;
   logic             iter_op;
   logic             md_last;
   logic             md_flag;
   logic [WIDTH-1:0] md_result;
   logic             sub_op;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] sum;
   logic             shift_over;
   logic [WIDTH-1:0] alu_c;
   logic             alu_cmp;

   assign accept  = start && !busy;
   assign iter_op = is_iterative(sel);

   alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .go     (accept && iter_op),
      .is_div (sel == OP_DIVU),
      .a      (A),
      .b      (B),
      .busy   (busy),
      .last   (md_last),
      .result (md_result),
      .flag   (md_flag)
   );

   // ADD and SUB share one adder; subtraction feeds ~B with a carry-in of one.
   assign sub_op     = (sel == OP_SUB);
   assign add_b      = sub_op ? ~B : B;
   assign sum        = A + add_b + {{(WIDTH-1){1'b0}}, sub_op};
   assign shift_over = (B >= SHAMT_LIMIT);

   always_comb begin
      alu_c   = B;
      alu_cmp = 1'b1;
      case (sel)
         OP_PASS: alu_c = B;
         OP_NOT:  alu_c = ~B;
         OP_AND:  alu_c = A & B;
         OP_OR:   alu_c = A | B;
         OP_XOR:  alu_c = A ^ B;
         OP_ADD:  alu_c = sum;
         OP_SUB:  alu_c = sum;
         OP_SLL:  alu_c = shift_over ? '0 : (A << B);
         OP_SRL:  alu_c = shift_over ? '0 : (A >> B);
         OP_SRA:  alu_c = shift_over ? {WIDTH{A[WIDTH-1]}} : WIDTH'($signed(A) >>> B);
         OP_EQZ:  alu_cmp = (A == '0);
         OP_NEZ:  alu_cmp = (A != '0);
         OP_GTZ:  alu_cmp = !A[WIDTH-1] && (A != '0);
         OP_LTZ:  alu_cmp = A[WIDTH-1];
         default: begin
            alu_c   = B;
            alu_cmp = 1'b1;
         end
      endcase
   end

   // Results only move on a completion; the iterative engine is never idle when it completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         C    <= '0;
         cmp  <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (md_last) begin
            C    <= md_result;
            cmp  <= md_flag;
            done <= 1'b1;
         end else if (accept && !iter_op) begin
            C    <= alu_c;
            cmp  <= alu_cmp;
            done <= 1'b1;
         end
      end
   end

endmodule
